// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch program-counter generator
//
// Produces the registered fetch PC. Each cycle it either holds (stall),
// steps by INC, or loads a trap / branch target. A redirect that arrives
// while stalled is parked in a one-entry pending register and applied on
// the first non-stalled edge. A pending trap cannot be displaced by a
// later branch.
//
// Ports
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   stall_i     hold the PC this cycle
//   trap_i      trap redirect request (highest priority)
//   trap_pc_i   trap target
//   redir_i     branch/jump redirect request
//   redir_pc_i  branch/jump target
//   pc_o        current fetch PC
//   flush_o     pulse: pc_o was just loaded from a non-sequential source
//   pending_o   a redirect is parked awaiting stall release
//   misalign_o  pulse: a misaligned target was rejected
//
// Build option
//   PC_GEN_ALIGN_CHECK_EN  defined   : misaligned targets are rejected and
//                                      reported on misalign_o
//                          undefined : target offset bits are cleared and
//                                      the target is used; misalign_o = 0
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INC          = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic                  redir_i,
    input  logic [DATA_WIDTH-1:0] redir_pc_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  flush_o,
    output logic                  pending_o,
    output logic                  misalign_o
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    localparam logic [DATA_WIDTH-1:0] OFF_MASK = DATA_WIDTH'(INC - 1);
    localparam logic [DATA_WIDTH-1:0] INC_V    = DATA_WIDTH'(INC);

    logic [0:0]            state_p0;
    logic [DATA_WIDTH-1:0] pc_p0;
    logic                  flush_p0;
    logic                  pend_trap_p0;
    logic [DATA_WIDTH-1:0] pend_pc_p0;

    logic                  trap_ok;
    logic                  redir_ok;
    logic [DATA_WIDTH-1:0] trap_tgt;
    logic [DATA_WIDTH-1:0] redir_tgt;

    logic [0:0]            state_nxt;
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic                  flush_nxt;
    logic                  pend_load;
    logic                  pend_trap_nxt;
    logic [DATA_WIDTH-1:0] pend_pc_nxt;
    logic                  pend_vld;
    logic                  pend_is_trap;

`ifdef PC_GEN_ALIGN_CHECK_EN
    function automatic logic is_aligned(input logic [DATA_WIDTH-1:0] t);
        return (t & OFF_MASK) == '0;
    endfunction

    logic misalign_p0;
    logic misalign_det;

    assign trap_ok   = trap_i  && is_aligned(trap_pc_i);
    assign redir_ok  = redir_i && is_aligned(redir_pc_i);
    assign trap_tgt  = trap_pc_i;
    assign redir_tgt = redir_pc_i;
    // A misaligned redir hidden behind an accepted trap is simply dropped,
    // so only targets that were actually in contention are reported.
    assign misalign_det = (trap_i && !is_aligned(trap_pc_i)) ||
                          (redir_i && !is_aligned(redir_pc_i) && !trap_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_p0 <= 1'b0;
        end else begin
            misalign_p0 <= misalign_det;
        end
    end

    assign misalign_o = misalign_p0;
`else
    function automatic logic [DATA_WIDTH-1:0] align_down(input logic [DATA_WIDTH-1:0] t);
        return t & ~OFF_MASK;
    endfunction

    assign trap_ok    = trap_i;
    assign redir_ok   = redir_i;
    assign trap_tgt   = align_down(trap_pc_i);
    assign redir_tgt  = align_down(redir_pc_i);
    assign misalign_o = 1'b0;
`endif

    assign pend_vld     = (state_p0 == PEND);
    assign pend_is_trap = pend_vld && pend_trap_p0;

    always_comb begin
        state_nxt     = state_p0;
        pc_nxt        = pc_p0;
        flush_nxt     = 1'b0;
        pend_load     = 1'b0;
        pend_trap_nxt = pend_trap_p0;
        pend_pc_nxt   = pend_pc_p0;

        if (stall_i) begin
            // Park the highest-priority live request; a parked trap is
            // never displaced by a branch.
            if (trap_ok) begin
                pend_load     = 1'b1;
                pend_trap_nxt = 1'b1;
                pend_pc_nxt   = trap_tgt;
                state_nxt     = PEND;
            end else if (redir_ok && !pend_is_trap) begin
                pend_load     = 1'b1;
                pend_trap_nxt = 1'b0;
                pend_pc_nxt   = redir_tgt;
                state_nxt     = PEND;
            end
        end else begin
            state_nxt = RUN;
            flush_nxt = 1'b1;
            if (trap_ok) begin
                pc_nxt = trap_tgt;
            end else if (pend_is_trap) begin
                pc_nxt = pend_pc_p0;
            end else if (redir_ok) begin
                pc_nxt = redir_tgt;
            end else if (pend_vld) begin
                pc_nxt = pend_pc_p0;
            end else begin
                pc_nxt    = pc_p0 + INC_V;
                flush_nxt = 1'b0;
            end
        end
    end

    // ---- stage p0: architectural PC and control state ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_p0     <= RUN;
            pc_p0        <= RESET_VECTOR;
            flush_p0     <= 1'b0;
            pend_trap_p0 <= 1'b0;
        end else begin
            state_p0     <= state_nxt;
            pc_p0        <= pc_nxt;
            flush_p0     <= flush_nxt;
            pend_trap_p0 <= pend_trap_nxt;
        end
    end

    // Pending target is qualified by state_p0, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (pend_load) begin
            pend_pc_p0 <= pend_pc_nxt;
        end
    end

    assign pc_o      = pc_p0;
    assign flush_o   = flush_p0;
    assign pending_o = pend_vld;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (DATA_WIDTH=32, RESET_VECTOR=0,
// INC=4). Directed scenarios followed by randomized traffic, all compared
// against a behavioural model of the PC selection rules.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    localparam int          INC = 4;
    localparam logic [31:0] RV  = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        trap_i;
    logic [31:0] trap_pc_i;
    logic        redir_i;
    logic [31:0] redir_pc_i;
    logic [31:0] pc_o;
    logic        flush_o;
    logic        pending_o;
    logic        misalign_o;

    int total  = 0;
    int passed = 0;

    // behavioural model state
    logic [31:0] m_pc;
    logic        m_flush;
    logic        m_mis;
    logic        m_pend;
    logic        m_ptrap;
    logic [31:0] m_ppc;

    pc_gen #(
        .DATA_WIDTH  (32),
        .RESET_VECTOR(RV),
        .INC         (INC)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .stall_i    (stall_i),
        .trap_i     (trap_i),
        .trap_pc_i  (trap_pc_i),
        .redir_i    (redir_i),
        .redir_pc_i (redir_pc_i),
        .pc_o       (pc_o),
        .flush_o    (flush_o),
        .pending_o  (pending_o),
        .misalign_o (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc    = RV;
        m_flush = 1'b0;
        m_mis   = 1'b0;
        m_pend  = 1'b0;
        m_ptrap = 1'b0;
        m_ppc   = 32'h0;
    endtask

    // One clock edge of the PC rules, written as a priority list.
    task automatic model_edge(input logic s, input logic t, input logic [31:0] tp,
                              input logic r, input logic [31:0] rp);
        logic        tok, rok, found;
        logic [31:0] tt, rt;
        logic        cv [4];
        logic [31:0] ct [4];
`ifdef PC_GEN_ALIGN_CHECK_EN
        tok   = t && (tp % INC == 0);
        rok   = r && (rp % INC == 0);
        tt    = tp;
        rt    = rp;
        m_mis = (t && (tp % INC != 0)) || (r && (rp % INC != 0) && !tok);
`else
        tok   = t;
        rok   = r;
        tt    = tp - (tp % INC);
        rt    = rp - (rp % INC);
        m_mis = 1'b0;
`endif
        if (s) begin
            m_flush = 1'b0;
            if (tok) begin
                m_pend = 1'b1; m_ptrap = 1'b1; m_ppc = tt;
            end else if (rok && !(m_pend && m_ptrap)) begin
                m_pend = 1'b1; m_ptrap = 1'b0; m_ppc = rt;
            end
        end else begin
            cv[0] = tok;               ct[0] = tt;
            cv[1] = m_pend && m_ptrap; ct[1] = m_ppc;
            cv[2] = rok;               ct[2] = rt;
            cv[3] = m_pend && !m_ptrap; ct[3] = m_ppc;
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && cv[i]) begin
                    found = 1'b1;
                    m_pc  = ct[i];
                end
            end
            if (!found) m_pc = m_pc + 32'(INC);
            m_flush = found;
            m_pend  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pc"},      pc_o,              m_pc);
        chk({tag, "_flush"},   {31'b0, flush_o},  {31'b0, m_flush});
        chk({tag, "_pending"}, {31'b0, pending_o}, {31'b0, m_pend});
        chk({tag, "_misalign"}, {31'b0, misalign_o}, {31'b0, m_mis});
    endtask

    task automatic step(input string tag, input logic s, input logic t, input logic [31:0] tp,
                        input logic r, input logic [31:0] rp);
        stall_i    = s;
        trap_i     = t;
        trap_pc_i  = tp;
        redir_i    = r;
        redir_pc_i = rp;
        @(posedge clk_i);
        model_edge(s, t, tp, r, rp);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic        s, t, r;
        logic [31:0] tp, rp;

        rst_ni     = 1'b0;
        stall_i    = 1'b0;
        trap_i     = 1'b0;
        trap_pc_i  = 32'h0;
        redir_i    = 1'b0;
        redir_pc_i = 32'h0;
        model_reset();

        // asynchronous reset values, before any clock edge
        #3;
        check_all("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // free run from reset: 4, 8, 12
        step("free1", 0, 0, 0, 0, 0);
        chk("free1_const", pc_o, 32'd4);
        step("free2", 0, 0, 0, 0, 0);
        step("free3", 0, 0, 0, 0, 0);
        chk("free3_const", pc_o, 32'd12);

        // plain redirect, then sequential
        step("redir", 0, 0, 0, 1, 32'h100);
        chk("redir_const", pc_o, 32'h100);
        chk("redir_flush", {31'b0, flush_o}, 32'd1);
        step("redir_next", 0, 0, 0, 0, 0);
        chk("redir_next_const", pc_o, 32'h104);

        // redirect parked under stall, overwritten by trap, released
        step("stall_redir", 1, 0, 0, 1, 32'h200);
        chk("stall_redir_pend", {31'b0, pending_o}, 32'd1);
        step("stall_trap", 1, 1, 32'h80, 0, 0);
        step("stall_redir2", 1, 0, 0, 1, 32'h300);
        chk("stall_hold_pc", pc_o, 32'h104);
        step("release", 0, 0, 0, 0, 0);
        chk("release_const", pc_o, 32'h80);
        chk("release_flush", {31'b0, flush_o}, 32'd1);

        // simultaneous trap and redir: trap wins, redir not queued
        step("both", 0, 1, 32'h80, 1, 32'h200);
        chk("both_const", pc_o, 32'h80);
        step("both_next", 0, 0, 0, 0, 0);
        chk("both_next_const", pc_o, 32'h84);

        // wrap-around
        step("to_top", 0, 0, 0, 1, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 0, 0, 0);
        chk("wrap_const", pc_o, 32'h0);
        chk("wrap_flush", {31'b0, flush_o}, 32'd0);

        // misaligned target
        step("mis_setup", 0, 0, 0, 1, 32'h40);
        step("misalign", 0, 0, 0, 1, 32'h102);
`ifdef PC_GEN_ALIGN_CHECK_EN
        chk("misalign_const", pc_o, 32'h44);
        chk("misalign_pulse", {31'b0, misalign_o}, 32'd1);
`else
        chk("misalign_const", pc_o, 32'h100);
        chk("misalign_pulse", {31'b0, misalign_o}, 32'd0);
`endif
        step("mis_after", 0, 0, 0, 0, 0);

        // reset in the middle of a pending redirect discards it
        step("pend_rst", 1, 0, 0, 1, 32'h500);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        #1;
        rst_ni = 1'b1;
        step("post_rst", 0, 0, 0, 0, 0);
        chk("post_rst_const", pc_o, RV + 32'(INC));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 9) < 3);
            t  = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 9) < 2);
            tp = $urandom;
            rp = $urandom;
            if ($urandom_range(0, 3) != 0) tp[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            step("rand", s, t, tp, r, rp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
